// File: rtl/nes_pkg.sv
//------------------------------------------------------------------------------
// nes_pkg : shared button indices, FSM state encoding and pad byte type for
//           the multi-pad NES controller poller.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nes_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } nes_state_e;

    typedef logic [7:0] pad_byte_t;

endpackage

`default_nettype wire

// File: rtl/nes_half_timer.sv
//------------------------------------------------------------------------------
// nes_half_timer : loadable down-counter; done_o pulses HALF_CYC (or
//                  2*HALF_CYC when long_i) cycles after load_i.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nes_half_timer #(
    parameter int HALF_CYC = 300
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic long_i,
    output logic done_o
);

    localparam int TW = (2 * HALF_CYC > 1) ? $clog2(2 * HALF_CYC) : 1;
    localparam logic [TW-1:0] C_LONG  = TW'(2 * HALF_CYC - 1);
    localparam logic [TW-1:0] C_SHORT = TW'(HALF_CYC - 1);

    logic [TW-1:0] count_q;
    logic          run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            run_q   <= 1'b0;
        end else if (load_i) begin
            count_q <= long_i ? C_LONG : C_SHORT;
            run_q   <= 1'b1;
        end else if (run_q) begin
            if (count_q == '0) begin
                run_q <= 1'b0;
            end else begin
                count_q <= count_q - TW'(1);
            end
        end
    end

    assign done_o = run_q && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/nes_multi_pad.sv
//------------------------------------------------------------------------------
// nes_multi_pad : polls NUM_PADS NES controllers over a shared clock/latch,
//                 producing button levels, press edges and a CPU IO word.
//                 Optional macro NES_TURBO_EN adds turbo_mask auto-fire.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nes_multi_pad
    import nes_pkg::*;
#(
    parameter int NUM_PADS = 2,
    parameter int HALF_CYC = 300,
    parameter int POLL_DIV = 833333
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PADS-1:0]   nes_data,
    output logic                  nes_clock,
    output logic                  nes_latch,
    input  logic [1:0]            pad_sel,
`ifdef NES_TURBO_EN
    input  logic [7:0]            turbo_mask,
`endif
    output logic [8*NUM_PADS-1:0] buttons,
    output logic [8*NUM_PADS-1:0] pressed,
    output logic                  frame_valid,
    output logic [15:0]           io_word
);

    localparam int PW    = 8 * NUM_PADS;
    localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    nes_state_e          state_q, state_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_PADS-1:0] sync1_q, sync2_q;
    logic [PW-1:0]       shift_q, shift_d;
    logic [PW-1:0]       buttons_q, pressed_q, level_mod;
    logic                frame_valid_q;
    logic                poll_tick, tmr_load, tmr_long, tmr_done;
    logic                sample_en, frame_done;

    assign poll_tick = (cnt_q == CNT_W'(POLL_DIV - 1));

    nes_half_timer #(
        .HALF_CYC (HALF_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (tmr_load),
        .long_i (tmr_long),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // A poll_tick outside IDLE is simply ignored; the counter keeps running.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        tmr_load  = 1'b0;
        tmr_long  = 1'b0;
        case (state_q)
            IDLE: if (poll_tick) begin
                state_d  = LATCH;
                tmr_load = 1'b1;
                tmr_long = 1'b1;
            end
            LATCH: if (tmr_done) begin
                state_d  = LOW;
                tmr_load = 1'b1;
            end
            LOW: if (tmr_done) begin
                if (bit_idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                end
            end
            HIGH: if (tmr_done) begin
                state_d   = LOW;
                tmr_load  = 1'b1;
                bit_idx_d = bit_idx_q + 3'd1;
            end
            DONE: begin
                state_d   = IDLE;
                bit_idx_d = 3'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nes_clock  = 1'b1;
        nes_latch  = 1'b0;
        sample_en  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            LATCH:   nes_latch = 1'b1;
            LOW: begin
                nes_clock = 1'b0;
                sample_en = tmr_done;
            end
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        if (sample_en) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                shift_d[8*p + int'(bit_idx_q)] = ~sync2_q[p];
            end
        end
    end

`ifdef NES_TURBO_EN
    logic [2:0] frame_cnt_q;

    // Masked buttons are gated by frame_cnt_q[2], toggling every 4 frames.
    always_comb begin
        level_mod = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            level_mod[8*p +: 8] = shift_q[8*p +: 8] &
                                  (~turbo_mask | {8{frame_cnt_q[2]}});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= 3'd0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 3'd1;
        end
    end
`else
    assign level_mod = shift_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            shift_q       <= '0;
            buttons_q     <= '0;
            pressed_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            cnt_q         <= poll_tick ? '0 : cnt_q + CNT_W'(1);
            sync1_q       <= nes_data;
            sync2_q       <= sync1_q;
            shift_q       <= shift_d;
            frame_valid_q <= frame_done;
            if (frame_done) begin
                buttons_q <= level_mod;
                pressed_q <= level_mod & ~buttons_q;
            end
        end
    end

    always_comb begin
        io_word = 16'h0000;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (pad_sel == 2'(p)) begin
                io_word = {pressed_q[8*p +: 8], buttons_q[8*p +: 8]};
            end
        end
    end

    assign buttons     = buttons_q;
    assign pressed     = pressed_q;
    assign frame_valid = frame_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_multi_pad.sv
//------------------------------------------------------------------------------
// tb_nes_multi_pad : directed self-checking bench for nes_multi_pad with
//                    behavioural NES pad models (HALF_CYC=4, POLL_DIV=200).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_nes_multi_pad;

    localparam int NP = 2;
    localparam int HC = 4;
    localparam int PD = 200;
    // poll_tick lands 199 cycles after reset release, then 17*HC+2 = 70 more.
    localparam int FIRST_FV = 269;

    logic          clk;
    logic          reset;
    logic [NP-1:0] nes_data;
    logic          nes_clock;
    logic          nes_latch;
    logic [1:0]    pad_sel;
    logic [15:0]   buttons;
    logic [15:0]   pressed;
    logic          frame_valid;
    logic [15:0]   io_word;
`ifdef NES_TURBO_EN
    logic [7:0]    turbo_mask;
`endif

    int compared   = 0;
    int mismatched = 0;
    int low_pulses = 0;
    int latch_cyc  = 0;

    logic [7:0] pad_press [NP];
    logic [7:0] pad_sr    [NP];

    nes_multi_pad #(
        .NUM_PADS (NP),
        .HALF_CYC (HC),
        .POLL_DIV (PD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nes_data    (nes_data),
        .nes_clock   (nes_clock),
        .nes_latch   (nes_latch),
        .pad_sel     (pad_sel),
`ifdef NES_TURBO_EN
        .turbo_mask  (turbo_mask),
`endif
        .buttons     (buttons),
        .pressed     (pressed),
        .frame_valid (frame_valid),
        .io_word     (io_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: latch loads the (active-low) button byte, each rising clock shifts.
    always @(posedge nes_latch or posedge nes_clock) begin
        for (int p = 0; p < NP; p++) begin
            if (nes_latch === 1'b1)
                pad_sr[p] <= ~pad_press[p];
            else if (nes_latch === 1'b0)
                pad_sr[p] <= {1'b1, pad_sr[p][7:1]};
        end
    end
    assign nes_data = {pad_sr[1][0], pad_sr[0][0]};

    always @(negedge nes_clock) if (reset === 1'b1) low_pulses++;
    always @(negedge clk) if (nes_latch === 1'b1) latch_cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fv(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_valid !== 1'b1 && n < limit);
    endtask

    int n, n2, base_low, base_latch;

    initial begin
        reset   = 1'b0;
        pad_sel = 2'd0;
        pad_press[0] = 8'h00;
        pad_press[1] = 8'h00;
        pad_sr[0] = 8'hFF;
        pad_sr[1] = 8'hFF;
`ifdef NES_TURBO_EN
        turbo_mask = 8'h00;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_nes_clock", 32'(nes_clock), 32'h1);
        check("rst_nes_latch", 32'(nes_latch), 32'h0);
        check("rst_buttons", 32'(buttons), 32'h0);
        check("rst_pressed", 32'(pressed), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_io_word", 32'(io_word), 32'h0);

        // 1: idle pads
        @(negedge clk);
        reset      = 1'b1;
        base_low   = low_pulses;
        base_latch = latch_cyc;
        wait_fv(400, n);
        check("t1_fv_latency", 32'(n), 32'(FIRST_FV));
        check("t1_buttons", 32'(buttons), 32'h0);
        check("t1_pressed", 32'(pressed), 32'h0);
        check("t1_clock_pulses", 32'(low_pulses - base_low), 32'd8);
        check("t1_latch_cycles", 32'(latch_cyc - base_latch), 32'd8);
        pad_press[0] = 8'h09;
        pad_press[1] = 8'h80;

        // 2: A+Start on pad 0, Right on pad 1
        wait_fv(400, n);
        check("t2_frame_period", 32'(n), 32'd200);
        check("t2_buttons", 32'(buttons), 32'h8009);
        check("t2_pressed", 32'(pressed), 32'h8009);
        check("t2_io_sel0", 32'(io_word), 32'h0909);
        pad_sel = 2'd1;
        #1;
        check("t2_io_sel1", 32'(io_word), 32'h8080);
        pad_sel = 2'd0;
        @(posedge clk);
        #1;
        check("t2_fv_one_cycle", 32'(frame_valid), 32'h0);
        repeat (49) @(posedge clk);
        #1;
        check("t2_pressed_hold", 32'(pressed), 32'h8009);

        // 3: same buttons held
        wait_fv(400, n);
        check("t3_frame_period", 32'(n), 32'd150);
        check("t3_buttons", 32'(buttons), 32'h8009);
        check("t3_pressed", 32'(pressed), 32'h0);
        check("t3_io_sel0", 32'(io_word), 32'h0009);
        pad_sel = 2'd1;
        #1;
        check("t3_io_sel1", 32'(io_word), 32'h0080);

        // 4: out-of-range selects
        pad_sel = 2'd3;
        #1;
        check("t4_io_sel3", 32'(io_word), 32'h0);
        pad_sel = 2'd2;
        #1;
        check("t4_io_sel2", 32'(io_word), 32'h0);
        pad_sel = 2'd0;

        // 5: reset during the fifth LOW phase
        base_low = low_pulses;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((low_pulses - base_low) < 5 && n < 400);
        check("t5_fifth_low_seen", 32'(low_pulses - base_low), 32'd5);
        check("t5_in_low", 32'(nes_clock), 32'h0);
        #1;
        reset = 1'b0;
        #1;
        check("t5_async_clock", 32'(nes_clock), 32'h1);
        check("t5_async_latch", 32'(nes_latch), 32'h0);
        check("t5_buttons", 32'(buttons), 32'h0);
        check("t5_pressed", 32'(pressed), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("t5_buttons_idle", 32'(buttons), 32'h0);
        wait_fv(400, n2);
        check("t5_fv_latency", 32'(100 + n2), 32'(FIRST_FV));
        check("t5_buttons_after", 32'(buttons), 32'h8009);
        check("t5_pressed_after", 32'(pressed), 32'h8009);

`ifdef NES_TURBO_EN
        // 6: turbo on A of pad 0
        reset        = 1'b0;
        pad_press[0] = 8'h01;
        pad_press[1] = 8'h00;
        turbo_mask   = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wait_fv(400, n);
            check("t6_fv_seen", 32'(frame_valid), 32'h1);
            check($sformatf("t6_buttons_f%0d", k), 32'(buttons),
                  (k >= 4 && k < 8) ? 32'h0001 : 32'h0000);
            check($sformatf("t6_pressed_f%0d", k), 32'(pressed),
                  (k == 4) ? 32'h0001 : 32'h0000);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nes_multi_pad.md
Name: nes_multi_pad

Overview:
- Parametrised successor to the single-pad NES controller interface: polls NUM_PADS NES controllers with one shared clock/latch pair, one serial data line per pad.
- Free-running poll at a programmable rate; produces debounced level snapshots, one-frame press-edge flags and a frame-valid strobe.
- Sits between the NES connector pins and the CPU IO input. A CPU-selectable 16-bit IO word replaces the fixed single-pad button output.

Parameters:
- NUM_PADS, 2, number of controllers (1..4).
- HALF_CYC, 300, clk cycles per half bit-period (6 us at 50 MHz).
- POLL_DIV, 833333, clk cycles between poll starts (60 Hz at 50 MHz); must exceed 20*HALF_CYC.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous active-low reset.
- nes_data  in  NUM_PADS  serial data per pad, active-low (0 = pressed).
- nes_clock  out  1  shared controller clock, idles high.
- nes_latch  out  1  shared latch, active-high.
- pad_sel  in  2  selects the pad driven onto io_word.
- buttons  out  8*NUM_PADS  active-high levels; pad p occupies [8p+7:8p]; bit order {Right,Left,Down,Up,Start,Select,B,A}, A = bit 0.
- pressed  out  8*NUM_PADS  rising-edge flags, valid for one poll frame.
- frame_valid  out  1  one-cycle strobe when buttons/pressed update.
- io_word  out  16  {pressed[sel], buttons[sel]}; reads 16'h0000 if pad_sel >= NUM_PADS.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Outputs: nes_clock = 1, nes_latch = 0, buttons = 0, pressed = 0, frame_valid = 0.
  - Internal state: FSM to IDLE, poll counter = 0, bit index = 0, synchronisers cleared.
- Input synchronisation: nes_data passes through a 2-flop synchroniser per pad; sampling uses the synchronised value.
- Poll counter: counts 0..POLL_DIV-1 and wraps. Wrap raises poll_tick for one cycle.
- FSM states:
  - IDLE: wait for poll_tick, then go to LATCH.
  - LATCH: nes_latch = 1 for 2*HALF_CYC cycles, then go to LOW.
  - LOW: nes_clock = 0 for HALF_CYC cycles. On the last cycle, shift ~sync_data[p] into shift register p at position bit_idx. If bit_idx == 7, go to DONE; otherwise go to HIGH.
  - HIGH: nes_clock = 1 for HALF_CYC cycles, increment bit_idx, return to LOW. The rising edge at LOW-to-HIGH is what shifts the pad.
  - DONE: one cycle. Then go to IDLE with bit_idx = 0.
- Update in DONE (registered, visible the following cycle):
  - buttons <= shift registers.
  - pressed <= shift & ~buttons_old.
  - frame_valid <= 1 for exactly one cycle.
- pressed holds until the next DONE, which overwrites it. A button held across frames reports pressed = 0 from the second frame onward.
- Poll overlap: a poll_tick arriving while not in IDLE is dropped; the next poll starts at the following tick. The poll counter never stalls.
- Latency: from poll_tick to frame_valid = 2*HALF_CYC + 8*HALF_CYC + 7*HALF_CYC + 2 cycles.
- io_word is combinational from the registered outputs and pad_sel. A pad_sel change is reflected in the same cycle.
- Reset mid-frame aborts the transaction immediately. nes_clock and nes_latch return to idle levels; no partial data reaches buttons.

Optional Feature:
- Macro NES_TURBO_EN.
- When defined:
  - Adds input turbo_mask[7:0] and an internal 3-bit frame counter.
  - For each pad, any held button whose mask bit is 1 has its buttons bit ANDed with frame_counter[2]. It auto-toggles every 4 frames.
  - pressed is computed from the turbo-modulated levels.
- When undefined: no port is added and there is no modulation.

Decomposition:
- Package nes_pkg:
  - Button index localparams BTN_A = 0 ... BTN_RIGHT = 7.
  - FSM state enum {IDLE, LATCH, LOW, HIGH, DONE}.
  - Typedef pad_byte_t (8 bits).
- Sub-module nes_half_timer: a loadable down-counter emitting a done pulse after HALF_CYC or 2*HALF_CYC cycles. It is reused by the LATCH, LOW and HIGH states.

Test Plan (HALF_CYC = 4, POLL_DIV = 200, NUM_PADS = 2):
1. Reset released, pads idle (nes_data = 2'b11) -> after first frame_valid: buttons = 16'h0000, pressed = 0; exactly 8 nes_clock low pulses; latch high 8 cycles.
2. Pad model 0 presents A+Start (bits 0 and 3 low), pad 1 presents Right -> buttons = 16'h8009; pressed = 16'h8009; io_word with pad_sel = 0 reads 16'h0909; with pad_sel = 1 reads 16'h8080.
3. Same inputs held for a second frame -> buttons unchanged, pressed = 0, io_word with pad_sel = 0 reads 16'h0009.
4. pad_sel = 3 -> io_word = 16'h0000.
5. Assert reset during the 5th LOW phase -> nes_clock = 1 and nes_latch = 0 asynchronously; buttons stay 0. After release, next frame timing starts from a poll_counter of 0.
6. NES_TURBO_EN defined, turbo_mask = 8'h01, A held on pad 0 -> buttons[0] reads 0 for frames 0-3, 1 for frames 4-7, 0 for frames 8-11; pressed[0] pulses on frame 4.
